// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types, select encodings and round-robin pick helper for the 4:1 arbiter.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package mux4_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [1:0] SEL_IN1 = 2'b00;
  localparam logic [1:0] SEL_IN2 = 2'b01;
  localparam logic [1:0] SEL_IN3 = 2'b10;
  localparam logic [1:0] SEL_IN4 = 2'b11;

  // Scan req starting at ptr, wrapping 3->0; returns {found, idx}.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/consumer bundle for the 4:1 round-robin arbiter.
// Latency: none (wiring only).
// Backpressure: out_ready from the consumer stalls the granted lane.
interface mux4_rr_arbiter_if #(
  parameter int DATA_W = 1
) ();
  logic [3:0]        req;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] in2;
  logic [DATA_W-1:0] in3;
  logic [DATA_W-1:0] in4;
  logic [3:0]        gnt;
  logic [1:0]        sel;
  logic [DATA_W-1:0] out;
  logic              out_valid;
  logic              out_ready;

  // Requester sources plus downstream consumer side.
  modport master (
    output req, in1, in2, in3, in4, out_ready,
    input  gnt, sel, out, out_valid
  );

  // Arbiter side.
  modport slave (
    input  req, in1, in2, in3, in4, out_ready,
    output gnt, sel, out, out_valid
  );
endinterface

// File: rtl/mux4_rr_arbiter_sel.sv
// Parameterized 4:1 data mux steered by the registered select.
// Latency: combinational.
// Backpressure: none; follows sel directly.
module mux4_sel
  import mux4_arb_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  output logic [DATA_W-1:0] out
);

  // Route the selected lane to out; in1 is the reset/default lane.
  always_comb begin
    out = in1;
    case (sel)
      SEL_IN1: out = in1;
      SEL_IN2: out = in2;
      SEL_IN3: out = in3;
      SEL_IN4: out = in4;
      default: out = in1;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter streaming one of four requester lanes to a valid/ready output.
// Latency: grant registered 1 cycle after req sampled; data path combinational from sel.
// Backpressure: out_ready=0 holds sel, gnt and beat count; release on dropped req still occurs.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int DATA_W    = 1,
  parameter int MAX_BURST = 4
) (
  input logic             clk,
  input logic             rst_n,
  mux4_rr_arbiter_if.slave bus
);

  localparam int                CNT_W     = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_t           state, state_n;
  logic [1:0]       sel_r, sel_n;
  logic [3:0]       gnt_r, gnt_n;
  logic [1:0]       ptr, ptr_n;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_n;

  logic             req_sel;
  logic             xfer;
  logic             rel;
  logic [1:0]       pick_ptr;
  logic [2:0]       pick;

  assign req_sel       = bus.req[sel_r];
  assign bus.out_valid = (state == GRANT) && req_sel;
  assign xfer          = bus.out_valid && bus.out_ready;
  // Release on the final beat of a burst, or as soon as the owner withdraws.
  assign rel           = (state == GRANT) && (!req_sel || (xfer && (beat_cnt == LAST_BEAT)));
  // Re-arbitration on release scans from the rotated pointer in the same edge.
  assign pick_ptr      = rel ? (sel_r + 2'd1) : ptr;
  assign pick          = rr_pick(bus.req, pick_ptr);

  assign bus.sel = sel_r;
  assign bus.gnt = gnt_r;

  mux4_sel #(
    .DATA_W(DATA_W)
  ) u_sel (
    .sel(sel_r),
    .in1(bus.in1),
    .in2(bus.in2),
    .in3(bus.in3),
    .in4(bus.in4),
    .out(bus.out)
  );

  // State, select/grant, rotation pointer and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel_r    <= SEL_IN1;
      gnt_r    <= 4'b0000;
      ptr      <= 2'd0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      sel_r    <= sel_n;
      gnt_r    <= gnt_n;
      ptr      <= ptr_n;
      beat_cnt <= beat_cnt_n;
    end
  end

  // Next-state: grant on request from IDLE, count beats, rotate and re-pick on release.
  always_comb begin
    state_n    = state;
    sel_n      = sel_r;
    gnt_n      = gnt_r;
    ptr_n      = ptr;
    beat_cnt_n = beat_cnt;
    case (state)
      IDLE: begin
        gnt_n = 4'b0000;
        if (pick[2]) begin
          state_n    = GRANT;
          sel_n      = pick[1:0];
          gnt_n      = 4'b0001 << pick[1:0];
          beat_cnt_n = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_n      = sel_r + 2'd1;
          beat_cnt_n = '0;
          if (pick[2]) begin
            sel_n = pick[1:0];
            gnt_n = 4'b0001 << pick[1:0];
          end else begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
          end
        end else if (xfer) begin
          beat_cnt_n = beat_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
      end
    endcase
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for the 4:1 round-robin arbiter.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled 1 unit later.
// Backpressure: out_ready driven directly from stimulus.
module tb_mux4_rr_arbiter;

  localparam int DW = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mux4_rr_arbiter_if #(.DATA_W(DW)) bus ();

  mux4_rr_arbiter #(
    .DATA_W(DW),
    .MAX_BURST(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] req_v);
    rst_n         = 1'b0;
    bus.req       = req_v;
    bus.out_ready = 1'b1;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  logic [1:0] exp_seq [20] = '{2'd0, 2'd0, 2'd0, 2'd0,
                               2'd1, 2'd1, 2'd1, 2'd1,
                               2'd2, 2'd2, 2'd2, 2'd2,
                               2'd3, 2'd3, 2'd3, 2'd3,
                               2'd0, 2'd0, 2'd0, 2'd0};
  logic [7:0] exp_dat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int xfers;
    int valids;
    n_checks = 0;
    n_fail   = 0;
    bus.in1  = 8'h11;
    bus.in2  = 8'h22;
    bus.in3  = 8'h33;
    bus.in4  = 8'h44;

    // 1: reset state, then reset mid-burst clears the rotation pointer.
    rst_n = 1'b0; bus.req = 4'hF; bus.out_ready = 1'b1;
    next_cycle(); next_cycle();
    #1;
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_sel", 32'(bus.sel), 32'h0);
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out", 32'(bus.out), 32'h11);
    rst_n = 1'b1;
    next_cycle(); #1;
    check("t1_gnt_in1", 32'(bus.gnt), 32'h1);
    repeat (4) next_cycle();
    #1;
    check("t1_rot_sel", 32'(bus.sel), 32'h1);
    next_cycle();
    rst_n = 1'b0;
    #1;
    check("t1_async_gnt", 32'(bus.gnt), 32'h0);
    check("t1_async_sel", 32'(bus.sel), 32'h0);
    check("t1_async_valid", 32'(bus.out_valid), 32'h0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle(); #1;
    check("t1_regrant_in1", 32'(bus.gnt), 32'h1);

    // 2: sole requester, continuous beats through rotations.
    do_reset(4'b0100);
    #1;
    check("t2_pre_gnt", 32'(bus.gnt), 32'h0);
    next_cycle(); #1;
    check("t2_gnt", 32'(bus.gnt), 32'h4);
    check("t2_sel", 32'(bus.sel), 32'h2);
    check("t2_out", 32'(bus.out), 32'h33);
    valids = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.out_valid === 1'b1 && bus.gnt === 4'b0100) valids++;
      next_cycle(); #1;
    end
    check("t2_no_bubble", 32'(valids), 32'd12);

    // 3: fairness across all four requesters.
    do_reset(4'hF);
    next_cycle(); #1;
    xfers = 0;
    for (int k = 0; k < 20; k++) begin
      check($sformatf("t3_sel%0d", k), 32'(bus.sel), 32'(exp_seq[k]));
      check($sformatf("t3_out%0d", k), 32'(bus.out), 32'(exp_dat[exp_seq[k]]));
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) xfers++;
      next_cycle(); #1;
    end
    check("t3_beats", 32'(xfers), 32'd20);

    // 4: backpressure holds the burst after two beats.
    do_reset(4'hF);
    next_cycle(); next_cycle(); next_cycle();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      next_cycle(); #1;
      check("t4_hold_sel", 32'(bus.sel), 32'h0);
      check("t4_hold_gnt", 32'(bus.gnt), 32'h1);
      check("t4_hold_out", 32'(bus.out), 32'h11);
      check("t4_hold_cnt", 32'(dut.beat_cnt), 32'd2);
    end
    bus.out_ready = 1'b1;
    next_cycle(); #1;
    check("t4_beat3_sel", 32'(bus.sel), 32'h0);
    next_cycle(); #1;
    check("t4_release_sel", 32'(bus.sel), 32'h1);
    check("t4_release_gnt", 32'(bus.gnt), 32'h2);

    // 5: in2 drops early; rotation skips in1.
    do_reset(4'hF);
    repeat (5) next_cycle();
    #1;
    check("t5_in2_gnt", 32'(bus.gnt), 32'h2);
    next_cycle();
    bus.req = 4'b1001;
    next_cycle(); #1;
    check("t5_gnt", 32'(bus.gnt), 32'h8);
    check("t5_sel", 32'(bus.sel), 32'h3);
    check("t5_out", 32'(bus.out), 32'h44);

    // 6: all requests drop, then a fresh request.
    next_cycle();
    bus.req = 4'b0000;
    next_cycle(); #1;
    check("t6_idle_gnt", 32'(bus.gnt), 32'h0);
    check("t6_idle_valid", 32'(bus.out_valid), 32'h0);
    check("t6_idle_sel", 32'(bus.sel), 32'h3);
    next_cycle();
    bus.req = 4'b0001;
    #1;
    check("t6_pre_gnt", 32'(bus.gnt), 32'h0);
    next_cycle(); #1;
    check("t6_gnt", 32'(bus.gnt), 32'h1);
    check("t6_sel", 32'(bus.sel), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
